acc_dump_decim: RTL

Integrate-and-dump decimator that sits directly downstream of the accumulator stage. It consumes that stage's signed sample stream, sums each block of DECIM accepted samples, then scales the block sum with round-half-up and saturates it to OUT_WIDTH. Each result goes into a 2-entry output buffer read through a valid/ready handshake. It is the rate-reducing stage between the accumulator and the slower back-end.

---
 rtl/dsp_pkg.sv | 61 ++++++
 rtl/acc_dump_decim_if.sv | 25 ++
 rtl/fifo2_sync.sv | 79 +++++++
 rtl/acc_dump_decim.sv | 114 +++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP helpers: width math, rounding shift, signed saturation and the
// occupancy encoding of the small output FIFO.
package dsp_pkg;

  // Wide working word for the scale/saturate path; comfortably larger than
  // any accumulator this block is built with.
  localparam int unsigned DspW = 64;

  typedef logic signed [DspW-1:0] dsp_word_t;

  typedef struct packed {
    logic      sat;
    dsp_word_t value;
  } sat_word_t;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } fifo_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Arithmetic right shift with round half toward +inf; shift 0 is a pass-through.
  function automatic dsp_word_t round_shift(input dsp_word_t value, input int unsigned shift);
    dsp_word_t half;
    half = (shift == 0) ? '0 : (dsp_word_t'(1) <<< (shift - 1));
    return (value + half) >>> shift;
  endfunction

  // Clip to the signed range of out_width bits and flag when clipping happened.
  function automatic sat_word_t sat_signed(input dsp_word_t value, input int unsigned out_width);
    dsp_word_t hi;
    dsp_word_t lo;
    sat_word_t res;
    hi = (dsp_word_t'(1) <<< (out_width - 1)) - dsp_word_t'(1);
    lo = -(dsp_word_t'(1) <<< (out_width - 1));
    res.sat   = 1'b0;
    res.value = value;
    if (value > hi) begin
      res.sat   = 1'b1;
      res.value = hi;
    end else if (value < lo) begin
      res.sat   = 1'b1;
      res.value = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/acc_dump_decim_if.sv
// Sample input and decimated-result output signals of acc_dump_decim.
interface acc_dump_decim_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned OUT_WIDTH = 8
);
  logic                        in_valid;
  logic signed [WIDTH-1:0]     in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_sat;
  logic                        overflow;

  // Producer of samples and consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_sat, overflow
  );

  // The decimator itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_sat, overflow
  );
endinterface

// File: rtl/fifo2_sync.sv
// Two-entry synchronous FIFO. The head entry sits in a fixed register so dout
// keeps showing the last head after the FIFO drains (zero after reset).
module fifo2_sync
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  fifo_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  do_push;
  logic                  do_pop;

  // Next occupancy and storage; push while full is only taken with a pop.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    do_pop  = pop && (state_q != StEmpty);
    do_push = push && ((state_q != StFull) || do_pop);
    unique case (state_q)
      StEmpty: begin
        if (do_push) begin
          head_d  = din;
          state_d = StOne;
        end
      end
      StOne: begin
        if (do_push && do_pop) begin
          head_d = din;
        end else if (do_push) begin
          tail_d  = din;
          state_d = StFull;
        end else if (do_pop) begin
          state_d = StEmpty;  // head register keeps the drained value
        end
      end
      StFull: begin
        if (do_pop) begin
          head_d = tail_q;
          if (do_push) begin
            tail_d = din;
          end else begin
            state_d = StOne;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign dout  = head_q;
  assign empty = (state_q == StEmpty);
  assign full  = (state_q == StFull);

endmodule

// File: rtl/acc_dump_decim.sv
// Integrate-and-dump decimator: sums DECIM accepted samples, rounds and
// shifts the block sum, saturates it to OUT_WIDTH and queues the result in a
// two-entry output FIFO.
module acc_dump_decim
  import dsp_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DECIM     = 4,
  parameter int unsigned SHIFT     = 2,
  parameter int unsigned OUT_WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  acc_dump_decim_if.slave bus
);

  localparam int unsigned ACC_WIDTH = WIDTH + clog2(DECIM);
  localparam int unsigned CNT_WIDTH = clog2(DECIM);
  localparam logic [CNT_WIDTH-1:0] LastCount = CNT_WIDTH'(DECIM - 1);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] dump_q, dump_d;
  logic [CNT_WIDTH-1:0]        count_q, count_d;
  logic                        dump_valid_q, dump_valid_d;
  logic                        overflow_q, overflow_d;

  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  dsp_word_t                   scaled;
  sat_word_t                   sat_res;
  logic                        unused_hi;

  logic [OUT_WIDTH:0]          fifo_din;
  logic [OUT_WIDTH:0]          fifo_dout;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic                        fifo_push;
  logic                        fifo_pop;

  assign in_ext = ACC_WIDTH'(bus.in_data);
  assign sum    = acc_q + in_ext;

  // Accumulate accepted samples; on the last sample of a block hand the sum
  // to the dump register and restart the block on the same edge.
  always_comb begin
    acc_d        = acc_q;
    count_d      = count_q;
    dump_d       = dump_q;
    dump_valid_d = 1'b0;
    if (bus.in_valid) begin
      if (count_q == LastCount) begin
        dump_d       = sum;
        dump_valid_d = 1'b1;
        acc_d        = '0;
        count_d      = '0;
      end else begin
        acc_d   = sum;
        count_d = count_q + CNT_WIDTH'(1);
      end
    end
  end

  // Scale and saturate straight off the dump register.
  always_comb begin
    scaled  = round_shift(dsp_word_t'(dump_q), SHIFT);
    sat_res = sat_signed(scaled, OUT_WIDTH);
  end

  assign fifo_din  = {sat_res.sat, sat_res.value[OUT_WIDTH-1:0]};
  assign unused_hi = ^sat_res.value[DspW-1:OUT_WIDTH];

  // A full buffer only takes the dump if the head leaves on the same edge.
  always_comb begin
    fifo_pop   = !fifo_empty && bus.out_ready;
    fifo_push  = dump_valid_q && (!fifo_full || fifo_pop);
    overflow_d = dump_valid_q && fifo_full && !fifo_pop;
  end

  // Block state, dump stage and overflow pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      count_q      <= '0;
      dump_q       <= '0;
      dump_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      count_q      <= count_d;
      dump_q       <= dump_d;
      dump_valid_q <= dump_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  fifo2_sync #(
    .DATA_WIDTH(OUT_WIDTH + 1)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_dout[OUT_WIDTH-1:0];
  assign bus.out_sat   = fifo_dout[OUT_WIDTH];
  assign bus.overflow  = overflow_q;

endmodule
